// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Optional build macro: UART_RX_MAJORITY_EN (3-sample majority vote per bit).
package uart_rx_pkg;

    localparam int unsigned DATA_WIDTH_DEF     = 8;
    localparam int unsigned PRESCALE_WIDTH_DEF = 6;

    // Legal oversampling ratios; anything else falls back to the default
    localparam int unsigned PRESCALE_8       = 8;
    localparam int unsigned PRESCALE_16      = 16;
    localparam int unsigned PRESCALE_32      = 32;
    localparam int unsigned PRESCALE_DEFAULT = PRESCALE_8;

    // Bits per frame without parity: start + payload + stop
    localparam int unsigned FRAME_BITS = 1 + DATA_WIDTH_DEF + 1;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // Map a raw prescale request onto a legal ratio
    function automatic int unsigned legal_prescale(input int unsigned p);
        if (p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32) begin
            return p;
        end
        return PRESCALE_DEFAULT;
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Serial-line and parallel-result bundle between the receiver and its neighbours.
interface uart_rx_frame_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
);
    logic                      RX_IN;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] PRESCALE;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      DATA_VALID;
    logic                      PAR_ERR;
    logic                      STP_ERR;

    // Line/config driver side
    modport master (
        output RX_IN, PAR_EN, PAR_TYP, PRESCALE,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    // Receiver side
    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, PRESCALE,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit sampler driven by the edge counter of the frame FSM.
// Default: single sample at edge P/2.
// UART_RX_MAJORITY_EN: 2-of-3 vote of edges P/2-1, P/2, P/2+1, valid from P/2+2.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned CNT_W = PRESCALE_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             rx_i,
    input  logic [CNT_W-1:0] edge_cnt_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             bit_o
);

    logic bit_q, bit_d;

`ifdef UART_RX_MAJORITY_EN
    logic early_q, early_d;
    logic mid_q, mid_d;

    // Capture the two leading samples, then vote with the live third sample
    always_comb begin
        early_d = early_q;
        mid_d   = mid_q;
        bit_d   = bit_q;
        if (en_i) begin
            if (edge_cnt_i == half_i - CNT_W'(1)) early_d = rx_i;
            if (edge_cnt_i == half_i)             mid_d   = rx_i;
            if (edge_cnt_i == half_i + CNT_W'(1)) begin
                bit_d = (early_q & mid_q) | (early_q & rx_i) | (mid_q & rx_i);
            end
        end
    end

    // Sample registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            early_q <= 1'b0;
            mid_q   <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            early_q <= early_d;
            mid_q   <= mid_d;
            bit_q   <= bit_d;
        end
    end
`else
    // Single mid-bit sample
    always_comb begin
        bit_d = bit_q;
        if (en_i && (edge_cnt_i == half_i)) bit_d = rx_i;
    end

    // Sample register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) bit_q <= 1'b0;
        else       bit_q <= bit_d;
    end
`endif

    assign bit_o = bit_q;

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART frame receiver: start, LSB-first payload, optional parity, stop.
// Accepted bytes appear on P_DATA with a one-cycle DATA_VALID; errors pulse PAR_ERR/STP_ERR.
// Optional build macro: UART_RX_MAJORITY_EN (majority-vote bit sampling, see uart_rx_sampler).
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    uart_rx_frame_if.slave  bus
);

    localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] IDLE   = 3'(RX_IDLE);
    localparam logic [2:0] START  = 3'(RX_START);
    localparam logic [2:0] DATA   = 3'(RX_DATA);
    localparam logic [2:0] PARITY = 3'(RX_PARITY);
    localparam logic [2:0] STOP   = 3'(RX_STOP);

    logic [2:0]                state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      perr_seen_q, perr_seen_d;
    logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
    logic                      data_valid_q, data_valid_d;
    logic                      par_err_q, par_err_d;
    logic                      stp_err_q, stp_err_d;

    logic                      last_edge;
    logic                      start_frame;
    logic                      sample_bit;
    logic                      par_expect;

    uart_rx_sampler #(
        .CNT_W (PRESCALE_WIDTH)
    ) u_sampler (
        .clk_i      (CLK),
        .rst_i      (RST),
        .en_i       (state_q != IDLE),
        .rx_i       (bus.RX_IN),
        .edge_cnt_i (edge_cnt_q),
        .half_i     (prescale_q >> 1),
        .bit_o      (sample_bit)
    );

    // Next-state, counters, shift register, checks and output pulses
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        perr_seen_d  = perr_seen_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        start_frame  = 1'b0;

        last_edge  = (edge_cnt_q == prescale_q - PRESCALE_WIDTH'(1));
        par_expect = (^shift_q) ^ par_typ_q;

        if (state_q != IDLE) begin
            edge_cnt_d = last_edge ? '0 : edge_cnt_q + PRESCALE_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (!bus.RX_IN) start_frame = 1'b1;
            end
            START: begin
                // A start bit that reads high at mid-bit was a glitch
                if (last_edge) state_d = sample_bit ? IDLE : DATA;
            end
            DATA: begin
                if (last_edge) begin
                    shift_d[bit_cnt_q] = sample_bit;
                    if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (last_edge) begin
                    if (par_expect != sample_bit) begin
                        perr_seen_d = 1'b1;
                        par_err_d   = 1'b1;
                    end
                    state_d = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    if (!sample_bit) stp_err_d = 1'b1;
                    if (sample_bit && !perr_seen_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                    // A low line here is taken as the next frame's start edge
                    if (!bus.RX_IN) start_frame = 1'b1;
                    else            state_d     = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase

        // The detecting cycle counts as edge 0 of the start bit
        if (start_frame) begin
            state_d     = START;
            edge_cnt_d  = PRESCALE_WIDTH'(1);
            bit_cnt_d   = '0;
            prescale_d  = PRESCALE_WIDTH'(legal_prescale(32'(bus.PRESCALE)));
            par_en_d    = bus.PAR_EN;
            par_typ_d   = bus.PAR_TYP;
            perr_seen_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            prescale_q   <= PRESCALE_WIDTH'(PRESCALE_DEFAULT);
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            perr_seen_q  <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            perr_seen_q  <= perr_seen_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.DATA_VALID = data_valid_q;
    assign bus.PAR_ERR    = par_err_q;
    assign bus.STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed scenarios plus randomized frames,
// compared every cycle against a frame-level event model.
module tb_uart_rx_frame;
    import uart_rx_pkg::*;

`ifdef UART_RX_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    uart_rx_frame_if bus ();

    uart_rx_frame dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: expected events keyed by the cycle number at which they must be visible
    logic [7:0] exp_v  [int];
    bit         exp_pe [int];
    bit         exp_se [int];
    logic [7:0] model_pdata = 8'h00;

    // Observed pulses
    int         dv_n = 0;
    int         pe_n = 0;
    int         se_n = 0;
    int         dv_cyc [$];
    logic [7:0] dv_dat [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                exp_v.delete();
                exp_pe.delete();
                exp_se.delete();
                model_pdata = 8'h00;
                chk("rst_DATA_VALID", 32'(bus.DATA_VALID), 0);
                chk("rst_PAR_ERR",    32'(bus.PAR_ERR),    0);
                chk("rst_STP_ERR",    32'(bus.STP_ERR),    0);
                chk("rst_P_DATA",     32'(bus.P_DATA),     0);
            end else begin
                if (exp_v.exists(cyc)) model_pdata = exp_v[cyc];
                chk("DATA_VALID", 32'(bus.DATA_VALID), 32'(exp_v.exists(cyc)));
                chk("PAR_ERR",    32'(bus.PAR_ERR),    32'(exp_pe.exists(cyc)));
                chk("STP_ERR",    32'(bus.STP_ERR),    32'(exp_se.exists(cyc)));
                chk("P_DATA",     32'(bus.P_DATA),     32'(model_pdata));
                if (exp_v.exists(cyc))  exp_v.delete(cyc);
                if (exp_pe.exists(cyc)) exp_pe.delete(cyc);
                if (exp_se.exists(cyc)) exp_se.delete(cyc);
            end
            if (bus.DATA_VALID === 1'b1) begin
                dv_n++;
                dv_cyc.push_back(cyc);
                dv_dat.push_back(bus.P_DATA);
            end
            if (bus.PAR_ERR === 1'b1) pe_n++;
            if (bus.STP_ERR === 1'b1) se_n++;
        end
    end

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame bit-by-bit and schedule its expected outcome.
    // spike: one-cycle inversion at mid-point of payload bit 2.
    // abort_after: stop driving after that many cycles (0 = full frame).
    task automatic send_frame(input logic [7:0] d, input int presc_in, input bit pen,
                              input bit ptyp, input bit bad_par, input bit bad_stop,
                              input bit spike, input int abort_after);
        int         p;
        int         n;
        int         c0;
        int         cnt;
        logic       bits [16];
        logic [7:0] rx_d;
        bit         perr;

        p = (presc_in == 8 || presc_in == 16 || presc_in == 32) ? presc_in : 8;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        n = 9;
        if (pen) begin
            bits[n] = ((^d) ^ ptyp) ^ bad_par;
            n++;
        end
        bits[n] = ~bad_stop;
        n++;

        rx_d = d;
        if (spike && !MAJ) rx_d[2] = ~rx_d[2];
        perr = pen && (bits[9] != ((^rx_d) ^ ptyp));

        c0 = cyc;
        if (perr)     exp_pe[c0 + 10 * p] = 1'b1;
        if (bad_stop) exp_se[c0 + (FRAME_BITS + 32'(pen)) * p] = 1'b1;
        if (!perr && !bad_stop) exp_v[c0 + (FRAME_BITS + 32'(pen)) * p] = rx_d;

        bus.PRESCALE = 6'(presc_in);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        cnt = 0;
        for (int b = 0; b < n; b++) begin
            for (int e = 0; e < p; e++) begin
                if (abort_after != 0 && cnt == abort_after) begin
                    bus.RX_IN = 1'b1;
                    return;
                end
                bus.RX_IN = bits[b] ^ (spike && b == 3 && e == p / 2);
                // Config changes mid-frame must not affect this frame
                if (b == 2 && e == 0) begin
                    bus.PRESCALE = 6'($urandom_range(0, 63));
                    bus.PAR_EN   = 1'($urandom);
                    bus.PAR_TYP  = 1'($urandom);
                end
                cnt++;
                @(negedge clk);
            end
        end
        bus.RX_IN = 1'b1;
    endtask

    initial begin
        int         c;
        int         n0;
        int         p0;
        int         s0;
        int         sel;
        int         pr;
        logic [7:0] d;
        bit         pen;
        bit         ptyp;
        bit         bpar;
        bit         bstop;

        bus.RX_IN    = 1'b1;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        bus.PRESCALE = 6'd8;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(5);

        // T1: P=8, no parity, 0xAA
        c = cyc; n0 = dv_n;
        send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(5);
        chk("t1_dv_count", 32'(dv_n - n0), 1);
        chk("t1_latency",  32'(dv_cyc[$] - c), 80);
        chk("t1_pdata",    32'(bus.P_DATA), 32'h AA);

        // T2: P=16 even parity, 0xBB then 0xCC back-to-back
        n0 = dv_n;
        send_frame(8'hBB, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        send_frame(8'hCC, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(5);
        chk("t2_dv_count", 32'(dv_n - n0), 2);
        chk("t2_spacing",  32'(dv_cyc[$] - dv_cyc[dv_cyc.size()-2]), 176);
        chk("t2_first",    32'(dv_dat[dv_dat.size()-2]), 32'h BB);
        chk("t2_second",   32'(dv_dat[$]), 32'h CC);

        // T3: P=8 odd parity, 0x0F with wrong parity bit
        n0 = dv_n; p0 = pe_n;
        send_frame(8'h0F, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        idle(20);
        chk("t3_par_err", 32'(pe_n - p0), 1);
        chk("t3_no_dv",   32'(dv_n - n0), 0);
        chk("t3_pdata",   32'(bus.P_DATA), 32'h CC);

        // T4: P=32, 0x55 with stop forced low, then good 0xDD
        n0 = dv_n; s0 = se_n;
        send_frame(8'h55, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        idle(70);
        chk("t4_stp_err", 32'(se_n - s0), 1);
        chk("t4_no_dv",   32'(dv_n - n0), 0);
        send_frame(8'hDD, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        idle(5);
        chk("t4_dv",    32'(dv_n - n0), 1);
        chk("t4_pdata", 32'(bus.P_DATA), 32'h DD);

        // T5: 3-cycle low glitch on idle line, P=16
        n0 = dv_n; p0 = pe_n; s0 = se_n;
        bus.PRESCALE = 6'd16;
        bus.RX_IN = 1'b0;
        repeat (3) @(negedge clk);
        idle(40);
        chk("t5_events", 32'((dv_n - n0) + (pe_n - p0) + (se_n - s0)), 0);
        chk("t5_pdata",  32'(bus.P_DATA), 32'h DD);

        // T6: reset mid-frame, then 0x3C with a mid-bit spike on payload bit 2
        send_frame(8'h77, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 50);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_rst_pdata", 32'(bus.P_DATA), 0);
        rst = 1'b0;
        idle(10);
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        idle(5);
        chk("t6_pdata", 32'(bus.P_DATA), MAJ ? 32'h 3C : 32'h 38);

        // Randomized frames
        for (int i = 0; i < 40; i++) begin
            d     = 8'($urandom);
            sel   = $urandom_range(0, 6);
            case (sel)
                0, 1:    pr = 8;
                2, 3:    pr = 16;
                4:       pr = 32;
                5:       pr = 12;
                default: pr = 0;
            endcase
            pen   = 1'($urandom);
            ptyp  = 1'($urandom);
            bpar  = ($urandom_range(0, 5) == 0);
            bstop = ($urandom_range(0, 6) == 0);
            send_frame(d, pr, pen, ptyp, bpar, bstop, 1'b0, 0);
            if (bstop)                       idle(70);
            else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20));
        end

        idle(80);
        chk("pending_events", 32'(exp_v.size() + exp_pe.size() + exp_se.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
